axil_reg_test_master: RTL

- Synthesizable AXI4-Lite master that runs the register write/read/compare self-test in hardware.
- Generalised in register count, base address, stride, data width and sequencing mode.
- Sits in front of any AXI4-Lite slave IP (e.g. the audio peripheral) in the block design, and reports pass/fail and error details to a status register or LED.

---
 rtl/axil_reg_test_master_if.sv | 41 ++++
 rtl/axil_reg_test_master.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_test_master_if.sv
// AXI4-Lite bus bundle between the register self-test master and the slave under test.
interface axil_reg_test_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_reg_test_master.sv
// AXI4-Lite master that writes a seeded pattern to a block of registers,
// reads it back, and reports pass/fail with details of the first failure.
//
// state     | meaning
// IDLE      | waiting for start
// WR_REQ    | AW and W valid until each handshakes
// WR_RESP   | waiting for B response
// RD_REQ    | AR valid until handshake
// RD_RESP   | waiting for R beat, compare against pattern
// ADV       | step index / switch phase (one idle bus cycle)
// FIN       | done pulse, latch pass
module axil_reg_test_master #(
    parameter int                     ADDR_WIDTH     = 32,
    parameter int                     DATA_WIDTH     = 32,
    parameter int                     NUM_REGS       = 4,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR      = '0,
    parameter int unsigned            ADDR_STRIDE    = 4,
    parameter int                     TIMEOUT_CYCLES = 256
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  start,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] seed,
    axil_reg_test_master_if.master m_axi,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [7:0]            err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_exp,
    output logic [DATA_WIDTH-1:0] fail_act
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_ADV, S_FIN
    } state_t;

    state_t                state, state_next;
    logic [8:0]            idx;
    logic [DATA_WIDTH-1:0] seed_q;
    logic                  mode_q;
    logic                  rd_phase;
    logic                  aw_done, w_done;
    logic [TW-1:0]         tmr;
    logic [31:0]           rot_amt;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] cur_pat;
    logic                  aw_hs, w_hs, wr_both, last_idx;
    logic                  tmo, wr_err, rd_err, err_ev;

    assign rot_amt  = {23'b0, idx} % 32'(DATA_WIDTH);
    assign cur_addr = BASE_ADDR + ADDR_WIDTH'(idx) * ADDR_WIDTH'(ADDR_STRIDE);
    assign cur_pat  = ((seed_q << rot_amt) | (seed_q >> (32'(DATA_WIDTH) - rot_amt)))
                      ^ DATA_WIDTH'(idx);
    assign last_idx = (idx == 9'(NUM_REGS - 1));

    assign m_axi.awaddr = cur_addr;
    assign m_axi.araddr = cur_addr;
    assign m_axi.wdata  = cur_pat;
    assign m_axi.awprot = 3'b000;
    assign m_axi.arprot = 3'b000;
    assign m_axi.wstrb  = '1;

    assign aw_hs   = m_axi.awvalid && m_axi.awready;
    assign w_hs    = m_axi.wvalid && m_axi.wready;
    assign wr_both = (aw_done || aw_hs) && (w_done || w_hs);

    // Phase timeout: the timer has run out and this cycle makes no progress.
    always_comb begin
        tmo = 1'b0;
        case (state)
            S_WR_REQ:  tmo = (tmr == '0) && !wr_both;
            S_WR_RESP: tmo = (tmr == '0) && !m_axi.bvalid;
            S_RD_REQ:  tmo = (tmr == '0) && !m_axi.arready;
            S_RD_RESP: tmo = (tmr == '0) && !m_axi.rvalid;
            default:   tmo = 1'b0;
        endcase
    end

    assign wr_err = (state == S_WR_RESP) && m_axi.bvalid && (m_axi.bresp != 2'b00);
    assign rd_err = (state == S_RD_RESP) && m_axi.rvalid &&
                    ((m_axi.rresp != 2'b00) || (m_axi.rdata != cur_pat));
    assign err_ev = wr_err || rd_err || tmo;

    // State register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= S_IDLE;
        else          state <= state_next;
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = S_WR_REQ;
            S_WR_REQ:  if (tmo) state_next = S_FIN;
                       else if (wr_both) state_next = S_WR_RESP;
            S_WR_RESP: if (tmo) state_next = S_FIN;
                       else if (m_axi.bvalid) state_next = mode_q ? S_ADV : S_RD_REQ;
            S_RD_REQ:  if (tmo) state_next = S_FIN;
                       else if (m_axi.arready) state_next = S_RD_RESP;
            S_RD_RESP: if (tmo) state_next = S_FIN;
                       else if (m_axi.rvalid) state_next = S_ADV;
            S_ADV: begin
                if (!mode_q)        state_next = last_idx ? S_FIN : S_WR_REQ;
                else if (!rd_phase) state_next = last_idx ? S_RD_REQ : S_WR_REQ;
                else                state_next = last_idx ? S_FIN : S_RD_REQ;
            end
            S_FIN:     state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Bus handshake and status outputs decoded from state.
    always_comb begin
        m_axi.awvalid = (state == S_WR_REQ) && !aw_done;
        m_axi.wvalid  = (state == S_WR_REQ) && !w_done;
        m_axi.bready  = (state == S_WR_RESP);
        m_axi.arvalid = (state == S_RD_REQ);
        m_axi.rready  = (state == S_RD_RESP);
        busy          = (state != S_IDLE) && (state != S_FIN);
        done          = (state == S_FIN);
    end

    // Run bookkeeping: index, timer, error counting and first-failure capture.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            idx       <= '0;
            seed_q    <= '0;
            mode_q    <= 1'b0;
            rd_phase  <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            tmr       <= '0;
            err_count <= '0;
            timeout   <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_act  <= '0;
        end else begin
            aw_done <= (state_next == S_WR_REQ) && (aw_done || aw_hs);
            w_done  <= (state_next == S_WR_REQ) && (w_done || w_hs);

            if (state_next != state) tmr <= TW'(TIMEOUT_CYCLES - 1);
            else if (tmr != '0)      tmr <= tmr - 1'b1;

            case (state)
                S_IDLE: if (start) begin
                    seed_q    <= seed;
                    mode_q    <= mode;
                    rd_phase  <= 1'b0;
                    idx       <= '0;
                    err_count <= '0;
                    timeout   <= 1'b0;
                    pass      <= 1'b0;
                    fail_addr <= '0;
                    fail_exp  <= '0;
                    fail_act  <= '0;
                end
                S_ADV: begin
                    if (mode_q && !rd_phase && last_idx) begin
                        idx      <= '0;
                        rd_phase <= 1'b1;
                    end else begin
                        idx <= idx + 9'd1;
                    end
                end
                S_FIN:   pass <= (err_count == 8'd0) && !timeout;
                default: ;
            endcase

            if (err_ev) begin
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                // err_count still zero means this is the run's first failure.
                if (err_count == 8'd0 && !tmo) begin
                    fail_addr <= cur_addr;
                    fail_exp  <= cur_pat;
                    fail_act  <= rd_err ? m_axi.rdata : '0;
                end
            end
            if (tmo) timeout <= 1'b1;
        end
    end
endmodule
